// File: rtl/dma_fifo_burst_ctrl.sv
// Read-side burst sequencer for the external-memory DMA FIFO: groups queued
// words into bounded bursts, requests the bus master, then streams one beat per pull.
module dma_fifo_burst_ctrl #(
  parameter int DWIDTH    = 64,
  parameter int AWIDTH    = 8,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              flush,
  input  logic [AWIDTH:0]   fifo_depth_left,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_data,
  output logic              fifo_pull,
  output logic              burst_req,
  input  logic              burst_gnt,
  output logic [AWIDTH:0]   burst_beats,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              flush_done
);

  localparam int              TW         = $clog2(TIMEOUT + 1);
  localparam logic [AWIDTH:0] FIFO_DEPTH = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] BLEN       = BURST_LEN[AWIDTH:0];
  localparam logic [AWIDTH:0] ONE        = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [TW-1:0]   TMAX       = TIMEOUT[TW-1:0];
  localparam logic [TW-1:0]   TONE       = {{(TW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AWIDTH:0] occ;
  logic [AWIDTH:0] beat_cnt;
  logic [TW-1:0]   timer;
  logic            flush_pend;
  logic            trigger;

  // depth_left never exceeds FIFO_DEPTH, so this subtraction cannot wrap
  assign occ    = FIFO_DEPTH - fifo_depth_left;
  assign m_data = fifo_data;
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    burst_req  = 1'b0;
    m_valid    = 1'b0;
    fifo_pull  = 1'b0;
    m_last     = 1'b0;
    flush_done = 1'b0;
    trigger    = enable && ((occ >= BLEN) ||
                            ((occ != '0) && (timer == TMAX)) ||
                            (flush_pend && (occ != '0)));
    case (state)
      IDLE: begin
        flush_done = flush_pend && (occ == '0);
        if (trigger) state_nxt = REQ;
      end
      REQ: begin
        // held until granted regardless of enable
        burst_req = 1'b1;
        if (burst_gnt) state_nxt = XFER;
      end
      XFER: begin
        m_valid   = !fifo_empty;
        fifo_pull = m_valid && m_ready;
        m_last    = m_valid && (beat_cnt == (burst_beats - ONE));
        if (fifo_pull && m_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_beats <= '0;
      beat_cnt    <= '0;
      timer       <= '0;
      flush_pend  <= 1'b0;
    end else begin
      if ((state == IDLE) && trigger) begin
        burst_beats <= (occ >= BLEN) ? BLEN : occ;
        beat_cnt    <= '0;
      end else if (fifo_pull) begin
        beat_cnt <= beat_cnt + ONE;
      end

      // timer only measures how long a partial FIFO has been sitting idle
      if ((state != IDLE) || (state_nxt != IDLE) || (occ == '0))
        timer <= '0;
      else if ((occ < BLEN) && (timer != TMAX))
        timer <= timer + TONE;

      if (flush)           flush_pend <= 1'b1;
      else if (flush_done) flush_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dma_fifo_burst_ctrl.sv
// Scoreboard bench for dma_fifo_burst_ctrl: behavioural FIFO in front, expected
// words and burst lengths queued at stimulus time and checked as beats leave.
module tb_dma_fifo_burst_ctrl;
  localparam int DW = 64;
  localparam int AW = 8;
  localparam int BL = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic [AW:0]   fifo_depth_left;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_pull;
  logic          burst_req;
  logic          burst_gnt = 1'b0;
  logic [AW:0]   burst_beats;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          flush_done;

  dma_fifo_burst_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .fifo_depth_left(fifo_depth_left), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_pull(fifo_pull), .burst_req(burst_req), .burst_gnt(burst_gnt),
    .burst_beats(burst_beats), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // behavioural FIFO sharing the DUT reset
  logic [DW-1:0] mem [256];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          push = 1'b0;
  logic [DW-1:0] push_data = '0;
  int            uf = 0;

  assign fifo_depth_left = 9'd256 - cnt;
  assign fifo_empty      = (cnt == '0);
  assign fifo_data       = mem[rp];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= push_data;
        wp      <= wp + 8'd1;
      end
      if (fifo_pull) begin
        rp <= rp + 8'd1;
        if (cnt == '0) uf <= uf + 1;
      end
      cnt <= cnt + {8'd0, push} - {8'd0, fifo_pull};
    end
  end

  logic [DW-1:0] exp_q [$];
  int            beats_q [$];

  int rdy_mode = 0;
  int gnt_max = 0;
  int gnt_edge = 0;
  int req_cyc = 0;
  int req_cnt = 0;
  int last_cnt = 0;
  int last_edge = -100;
  int done_cyc = -1;
  int done_cnt = 0;
  int cur_len = 0;
  int beat_idx = 0;
  int last_push_edge = 0;
  int flush_edge = 0;

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : (rdy_mode == 0);
  end

  initial forever begin
    int d;
    @(posedge clk);
    #1;
    if (rst_n && burst_req) begin
      d = int'($urandom_range(0, gnt_max));
      repeat (d) begin
        @(posedge clk);
        #1;
        chk("req_hold", burst_req, 1);
      end
      burst_gnt = 1'b1;
      gnt_edge  = cyc + 1;
      @(posedge clk);
      #1;
      burst_gnt = 1'b0;
    end
  end

  initial begin : monitor
    logic          req_prev;
    logic          stall_prev;
    logic          first_valid;
    logic [DW-1:0] stall_data;
    req_prev = 1'b0;
    stall_prev = 1'b0;
    first_valid = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req_prev = 1'b0;
        stall_prev = 1'b0;
        first_valid = 1'b0;
        beat_idx = 0;
      end else begin
        if (burst_req && !req_prev) begin
          req_cnt++;
          req_cyc = cyc;
          chk("gap", (cyc - last_edge) >= 1, 1);
          if (beats_q.size() == 0) begin
            chk("unexp_req", 1, 0);
            cur_len = int'(burst_beats);
          end else begin
            cur_len = beats_q.pop_front();
            chk("burst_beats", burst_beats, cur_len);
          end
          beat_idx = 0;
          first_valid = 1'b1;
        end
        req_prev = burst_req;
        if (stall_prev) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_data", m_data, stall_data);
        end
        if (!m_ready) chk("pull_stall", fifo_pull, 0);
        if (m_valid) begin
          if (first_valid) begin
            chk("gnt_to_valid", cyc, gnt_edge);
            first_valid = 1'b0;
          end
          chk("m_last", m_last, beat_idx == cur_len - 1);
          if (m_ready) begin
            if (exp_q.size() == 0) chk("extra_beat", 1, 0);
            else                   chk("m_data", m_data, exp_q.pop_front());
            beat_idx++;
            if (m_last) begin
              last_cnt++;
              last_edge = cyc + 1;
            end
          end
        end
        stall_prev = m_valid && !m_ready;
        stall_data = m_data;
        if (flush_done) begin
          done_cyc = cyc;
          done_cnt++;
        end
      end
    end
  end

  task automatic push_word();
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    push_data = d;
    push = 1'b1;
    exp_q.push_back(d);
    @(posedge clk);
    #1;
    push = 1'b0;
    last_push_edge = cyc;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) push_word();
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    flush_edge = cyc;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || beats_q.size() != 0 || busy) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= budget) chk(tag, 0, 1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_pull"}, fifo_pull, 0);
    chk({pfx, "_req"}, burst_req, 0);
    chk({pfx, "_beats"}, burst_beats, 0);
    chk({pfx, "_valid"}, m_valid, 0);
    chk({pfx, "_last"}, m_last, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, flush_done, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int l0, r0, d0, p, k;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // threshold burst with immediate grant and ready held high
    enable = 1'b1;
    l0 = last_cnt;
    beats_q.push_back(16);
    push_n(16);
    p = last_push_edge;
    wait_drain(200, "t1_drain_timeout");
    chk("t1_req_lat", req_cyc - p, 1);
    chk("t1_consec", last_edge - gnt_edge, 16);
    chk("t1_depth", fifo_depth_left, 256);
    chk("t1_lasts", last_cnt - l0, 1);

    // 40 words preloaded while disabled: 16, 16, then an 8-beat timeout burst
    enable = 1'b0;
    r0 = req_cnt;
    l0 = last_cnt;
    push_n(40);
    repeat (4) @(posedge clk);
    #1;
    chk("t2_no_req", req_cnt - r0, 0);
    chk("t2_req_low", burst_req, 0);
    beats_q.push_back(16);
    beats_q.push_back(16);
    beats_q.push_back(8);
    enable = 1'b1;
    wait_drain(400, "t2_drain_timeout");
    chk("t2_lasts", last_cnt - l0, 3);
    chk("t2_depth", fifo_depth_left, 256);

    // three words left alone: timeout burst
    beats_q.push_back(3);
    push_word();
    p = last_push_edge;
    push_n(2);
    wait_drain(300, "t3_drain_timeout");
    chk("t3_req_lat", req_cyc - p, TO + 1);

    // flush of a short queue, then flush of an empty FIFO
    d0 = done_cnt;
    beats_q.push_back(5);
    push_n(5);
    pulse_flush();
    p = flush_edge;
    wait_drain(200, "t4_drain_timeout");
    repeat (3) @(posedge clk);
    #1;
    chk("t4_req_lat", req_cyc - p, 1);
    chk("t4_done_cyc", done_cyc, last_edge);
    chk("t4_done_cnt", done_cnt - d0, 1);
    r0 = req_cnt;
    d0 = done_cnt;
    pulse_flush();
    p = flush_edge;
    repeat (3) @(posedge clk);
    #1;
    chk("t4e_done_cyc", done_cyc, p);
    chk("t4e_done_cnt", done_cnt - d0, 1);
    chk("t4e_no_req", req_cnt - r0, 0);

    // random backpressure and grant latency; flush drains the 5-word tail
    rdy_mode = 1;
    gnt_max = 7;
    enable = 1'b0;
    l0 = last_cnt;
    d0 = done_cnt;
    push_n(37);
    beats_q.push_back(16);
    beats_q.push_back(16);
    beats_q.push_back(5);
    enable = 1'b1;
    pulse_flush();
    wait_drain(2000, "t5_drain_timeout");
    repeat (3) @(posedge clk);
    #1;
    chk("t5_lasts", last_cnt - l0, 3);
    chk("t5_done_cnt", done_cnt - d0, 1);
    rdy_mode = 0;
    gnt_max = 0;

    // asynchronous reset in the middle of a burst
    enable = 1'b0;
    push_n(16);
    beats_q.push_back(16);
    enable = 1'b1;
    k = 0;
    while (beat_idx < 7 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 200) chk("t6_reach_timeout", 0, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6rst");
    exp_q.delete();
    beats_q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    r0 = req_cnt;
    repeat (100) @(posedge clk);
    #1;
    chk("t6_no_req", req_cnt - r0, 0);
    beats_q.push_back(16);
    push_n(16);
    wait_drain(200, "t6_drain_timeout");
    chk("t6_req_again", req_cnt - r0, 1);

    chk("underflow", uf, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dma_fifo_burst_ctrl.md
# dma_fifo_burst_ctrl

Read-side sequencer for the external-memory DMA FIFO. It watches FIFO occupancy and groups queued words into bounded bursts. For each burst it requests the downstream bus master, then drives one FIFO pull per accepted beat with valid/ready flow control and a last-beat marker. A partial burst is flushed on timeout or on an explicit flush. It sits between the FIFO's pull/data_out/depth_left side and the AXI write-data path.

## Interface
- DWIDTH, 64, FIFO data width
- AWIDTH, 8, FIFO address width; FIFO_DEPTH = 1<<AWIDTH
- BURST_LEN, 16, maximum beats per burst (1..FIFO_DEPTH)
- TIMEOUT, 64, idle cycles with a partial FIFO before a short burst is forced (≥1)

Ports:
- clks.clk  in  1  clock, from AXI_clks.to_rtl clks
- clks.rst  in  1  reset, asynchronous, active-low
- enable  in  1  permits new bursts
- flush  in  1  pulse; drain everything currently queued, ignoring BURST_LEN threshold
- fifo_depth_left  in  AWIDTH+1  free entries reported by FIFO
- fifo_empty  in  1  FIFO empty
- fifo_data  in  DWIDTH  FIFO data_out (combinational read at read pointer)
- fifo_pull  out  1  FIFO pull strobe
- burst_req  out  1  burst request to bus master
- burst_gnt  in  1  grant, sampled while burst_req=1
- burst_beats  out  AWIDTH+1  beat count of requested/current burst
- m_valid  out  1  beat valid
- m_ready  in  1  beat accepted when m_valid&&m_ready
- m_data  out  DWIDTH  beat data
- m_last  out  1  final beat of burst
- busy  out  1  state != IDLE
- flush_done  out  1  one-cycle pulse when a flush completes

## Operation
- occ = FIFO_DEPTH − fifo_depth_left, AWIDTH+1 bits unsigned; never wraps because depth_left ≤ FIFO_DEPTH.
- FSM states IDLE, REQ, XFER.
- IDLE→REQ when enable and any of:
  - occ ≥ BURST_LEN
  - occ≠0 and timer==TIMEOUT
  - flush_pend and occ≠0
- On IDLE→REQ, latch burst_beats = min(occ, BURST_LEN) and clear beat_cnt.
- REQ: burst_req=1. burst_gnt=1 → XFER. burst_req is held until grant; it is never withdrawn, even if enable drops.
- XFER:
  - m_valid = !fifo_empty; m_data = fifo_data; fifo_pull = m_valid && m_ready.
  - Each accepted beat increments beat_cnt.
  - m_last = m_valid && (beat_cnt == burst_beats−1).
  - Accepted last beat → IDLE.
- Only this block pulls the FIFO, so occ ≥ burst_beats for the whole burst. The fifo_empty gate is defensive only.
- Timer:
  - Counts +1 per cycle in IDLE while 0 < occ < BURST_LEN, saturating at TIMEOUT.
  - Cleared when occ==0, on leaving IDLE, and in reset.
- Flush:
  - A flush pulse in any state sets flush_pend.
  - In IDLE with flush_pend and occ==0: clear flush_pend, pulse flush_done for one cycle.
  - Flush of an already-empty FIFO: flush_done one cycle after the pulse.
- enable low: in-progress REQ/XFER completes normally; no new burst starts. flush_pend is retained until enable returns.
- Simultaneous pushes during a burst are not counted toward the current burst; they are handled by the next burst.

## Timing
- Reset (async assert, any state): state IDLE; all of the following are 0: fifo_pull, burst_req, burst_beats, m_valid, m_last, busy, flush_done, timer, beat_cnt, flush_pend.
- Release is synchronous to clks.clk. The FIFO shares this reset, so reset mid-burst discards the burst with no partial-burst recovery.
- Threshold burst: trigger true at edge t → burst_req=1 from t+1.
- Grant: burst_gnt sampled high at edge g → m_valid from g+1.
- Throughput: 1 beat/cycle while m_ready=1. m_valid/m_data stay stable while m_ready=0.
- Gap: at least one IDLE cycle between consecutive bursts (last beat at edge e → earliest new burst_req at e+2).
- fifo_pull is combinational with m_ready. The FIFO updates r_ptr/depth_left at the same edge the beat is accepted.
- Timeout burst: burst_req rises TIMEOUT+1 cycles after occ first becomes nonzero while below BURST_LEN.

## Test plan
- FIFO preloaded with 16 words, gnt immediate, m_ready=1 → burst_beats=16; 16 consecutive pulls; m_last on word 16 only; depth_left returns to 256.
- 40 words queued, BURST_LEN=16 → bursts of 16, 16, then 8 after TIMEOUT; each burst has exactly one m_last; data order preserved.
- 3 words queued, no further pushes → burst_req exactly 65 cycles after occ=1; burst_beats=3.
- 5 words queued, flush pulse → immediate 5-beat burst; flush_done one cycle after return to IDLE. Flush with empty FIFO → flush_done next cycle, no burst_req.
- Random m_ready (50%) and burst_gnt delay 0–7 → no pull while m_ready=0; m_data stable under stall; no FIFO underflow assertion fires.
- Async reset mid-XFER at beat 7 → all outputs 0 immediately; after release, no burst_req until the trigger conditions are met again.
